// File: rtl/layer_skew_buffer.sv
// layer_skew_buffer: per-layer skew delay lines aligning R rows and Y elements to the K-best detector stages
`ifndef WL
`define WL 16
`endif
module layer_skew_buffer #(
  parameter int LAYERS = 8,
  parameter int WL = `WL,
  parameter int STAGE_LAT = 4,
  parameter int FIRST_LAT = 1,
  parameter int CW = $clog2(FIRST_LAT + STAGE_LAT*(LAYERS-2) + 2)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            flush,
  input  logic                            in_valid,
  input  logic [LAYERS*(LAYERS+1)/2*WL-1:0] Rmat,
  input  logic [LAYERS*WL-1:0]            Yarr,
  output logic [LAYERS*(LAYERS+1)/2*WL-1:0] R_out,
  output logic [LAYERS*WL-1:0]            Y_out,
  output logic [LAYERS-1:0]               v_out,
  output logic [CW-1:0]                   inflight,
  output logic                            busy
);
  for (genvar j = 0; j < LAYERS; j++) begin : g_layer
    localparam int N = (LAYERS-j)*WL;
    localparam int O = (j*LAYERS - j*(j-1)/2)*WL;
    localparam int D = (j == LAYERS-1) ? 0 : FIRST_LAT + STAGE_LAT*(LAYERS-2-j);
    if (D == 0) begin : g_pass
      assign R_out[O +: N] = Rmat[O +: N];
      assign Y_out[j*WL +: WL] = Yarr[j*WL +: WL];
      assign v_out[j] = in_valid & en;
    end else begin : g_line
      logic [N+WL-1:0] d [D];
      logic [D-1:0]    v;
      // data shifts on every advancing cycle; only the valid tags see flush
      always_ff @(posedge clk or negedge rst)
        if (!rst) begin
          d <= '{default: '0};
          v <= '0;
        end else begin
          if (en) begin
            d[0] <= {Yarr[j*WL +: WL], Rmat[O +: N]};
            for (int k = 1; k < D; k++) d[k] <= d[k-1];
          end
          if (flush) v <= '0;
          else if (en) v <= D'({v, in_valid});
        end
      assign {Y_out[j*WL +: WL], R_out[O +: N]} = d[D-1];
      assign v_out[j] = v[D-1];
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) inflight <= '0;
    else if (flush) inflight <= '0;
    else if (en) inflight <= inflight + CW'(in_valid) - CW'(v_out[0]);
  assign busy = |inflight;
endmodule
